// File: rtl/oled_pkg.sv
// Shared types and constant tables for the SSD1331-class OLED controller:
// FSM state encodings, the power-up command list, window opcodes and the
// colour-bar table used by the optional test pattern (OLED_TEST_PATTERN_EN).
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_INIT,
        ST_FRAME_CMD,
        ST_FETCH,
        ST_WRITE
    } oled_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_E_HIGH,
        WR_E_LOW
    } wr_phase_t;

    // Display off, remap/colour depth, start line, offset, normal mode,
    // multiplex ratio 64, master config, display on.
    localparam int INIT_LEN = 13;
    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        8'hAE, 8'hA0, 8'h32, 8'hA1, 8'h00, 8'hA2, 8'h00,
        8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF
    };

    localparam int         FRAME_CMD_LEN = 6;
    localparam logic [7:0] OP_SET_COL    = 8'h15;
    localparam logic [7:0] OP_SET_ROW    = 8'h75;

    // RGB332 colours for the eight vertical test bars, left to right.
    localparam logic [7:0] BAR_COLORS [8] = '{
        8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
    };

    // Per-frame window: full column range then full row range.
    function automatic logic [7:0] frame_cmd_byte(input logic [3:0] idx,
                                                  input int width,
                                                  input int height);
        case (idx)
            4'd0:    return OP_SET_COL;
            4'd1:    return 8'h00;
            4'd2:    return 8'(width - 1);
            4'd3:    return OP_SET_ROW;
            4'd4:    return 8'h00;
            default: return 8'(height - 1);
        endcase
    endfunction

endpackage

// File: rtl/oled_byte_writer.sv
// 6800-style single byte strobe: one SETUP cycle, CLK_DIV cycles with E high,
// CLK_DIV cycles with E low. dc/dout are held for the whole byte.
// Handshake: start is accepted only while busy=0; done is high during the
// last E-low cycle of the byte, the cycle before busy drops.
module oled_byte_writer
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dc_in,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       e,
    output logic       dc,
    output logic [7:0] dout
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    wr_phase_t        phase;
    logic [DIV_W-1:0] cnt;

    // Phase sequencer with registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= WR_IDLE;
            cnt   <= '0;
            e     <= 1'b0;
            dc    <= 1'b0;
            dout  <= 8'h00;
        end else begin
            case (phase)
                WR_IDLE: begin
                    if (start) begin
                        phase <= WR_SETUP;
                        dc    <= dc_in;
                        dout  <= data_in;
                    end
                end
                WR_SETUP: begin
                    phase <= WR_E_HIGH;
                    e     <= 1'b1;
                    cnt   <= '0;
                end
                WR_E_HIGH: begin
                    if (cnt == DIV_LAST) begin
                        phase <= WR_E_LOW;
                        e     <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                WR_E_LOW: begin
                    if (cnt == DIV_LAST) begin
                        phase <= WR_IDLE;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: phase <= WR_IDLE;
            endcase
        end
    end

    assign busy = (phase != WR_IDLE);
    assign done = (phase == WR_E_LOW) && (cnt == DIV_LAST);

endmodule

// File: rtl/oled_ctrl.sv
// OLED controller top: panel reset and power-up, init command list, then a
// continuous refresh of window commands followed by WIDTH*HEIGHT pixel bytes
// fetched from the tilemap layer. Optional macro OLED_TEST_PATTERN_EN adds a
// test_pattern input that substitutes eight vertical colour bars.
// Pixel period: one address-setup cycle, one request cycle, PIXEL_LATENCY
// wait, start hand-off, then the 2*CLK_DIV+1 byte (14 cycles at defaults).
module oled_ctrl
    import oled_pkg::*;
#(
    parameter int WIDTH         = 96,
    parameter int HEIGHT        = 64,
    parameter int CLK_DIV       = 4,
    parameter int RST_CYCLES    = 1000,
    parameter int WAIT_CYCLES   = 1000,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef OLED_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        pixel_re,
    output logic [12:0] pixel_addr,
    input  logic [7:0]  pixel_data,
    output logic        frame_done,
    output logic        oled_cs,
    output logic        oled_rst,
    output logic        oled_dc,
    output logic        oled_e,
    output logic [7:0]  oled_dout
);

    localparam int NPIX    = WIDTH * HEIGHT;
    localparam int ADDR_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LAT_W   = $clog2(PIXEL_LATENCY + 2);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    // pixel_re is issued at lat_cnt==0 and visible at 1; data arrives
    // PIXEL_LATENCY cycles after that.
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(PIXEL_LATENCY + 1);

    oled_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        cmd_idx;
    logic              pend;
    logic [ADDR_W-1:0] addr;
    logic [LAT_W-1:0]  lat_cnt;
    logic              wr_start;
    logic              wr_dc;
    logic [7:0]        wr_data;
    logic              wr_busy;
    logic              wr_done;
    logic [7:0]        pixel_byte;

`ifdef OLED_TEST_PATTERN_EN
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [XW-1:0] x_cnt;
    logic [2:0]    bar_idx;

    assign bar_idx    = 3'((32'(x_cnt) * 8) / WIDTH);
    assign pixel_byte = test_pattern ? BAR_COLORS[bar_idx] : pixel_data;

    // Column tracker for the bar pattern, kept in step with addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
        end else if (state == ST_WRITE && wr_done) begin
            if (x_cnt == XW'(WIDTH - 1) || addr == ADDR_LAST) x_cnt <= '0;
            else                                              x_cnt <= x_cnt + XW'(1);
        end
    end
`else
    assign pixel_byte = pixel_data;
`endif

    // Top sequencer: power-up, command bytes, and the fetch/write pixel loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RST_HOLD;
            cnt      <= '0;
            cmd_idx  <= '0;
            pend     <= 1'b0;
            addr     <= '0;
            lat_cnt  <= '0;
            wr_start <= 1'b0;
            wr_dc    <= 1'b0;
            wr_data  <= 8'h00;
            pixel_re <= 1'b0;
            oled_cs  <= 1'b1;
            oled_rst <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            pixel_re <= 1'b0;
            case (state)
                ST_RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        state    <= ST_RST_WAIT;
                        oled_rst <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state   <= ST_INIT;
                        oled_cs <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (!pend) begin
                        wr_start <= 1'b1;
                        wr_dc    <= 1'b0;
                        wr_data  <= INIT_CMDS[cmd_idx];
                        pend     <= 1'b1;
                    end else if (wr_done) begin
                        pend <= 1'b0;
                        if (cmd_idx == 4'(INIT_LEN - 1)) begin
                            cmd_idx <= '0;
                            state   <= ST_FRAME_CMD;
                        end else begin
                            cmd_idx <= cmd_idx + 4'd1;
                        end
                    end
                end
                ST_FRAME_CMD: begin
                    if (!pend) begin
                        wr_start <= 1'b1;
                        wr_dc    <= 1'b0;
                        wr_data  <= frame_cmd_byte(cmd_idx, WIDTH, HEIGHT);
                        pend     <= 1'b1;
                    end else if (wr_done) begin
                        pend <= 1'b0;
                        if (cmd_idx == 4'(FRAME_CMD_LEN - 1)) begin
                            cmd_idx <= '0;
                            lat_cnt <= '0;
                            state   <= ST_FETCH;
                        end else begin
                            cmd_idx <= cmd_idx + 4'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_cnt == '0) pixel_re <= 1'b1;
                    if (lat_cnt == LAT_LAST) begin
                        wr_start <= 1'b1;
                        wr_dc    <= 1'b1;
                        wr_data  <= pixel_byte;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_done) begin
                        lat_cnt <= '0;
                        if (addr == ADDR_LAST) begin
                            addr  <= '0;
                            state <= ST_FRAME_CMD;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_RST_HOLD;
            endcase
        end
    end

    assign pixel_addr = 13'(addr);
    assign frame_done = (state == ST_WRITE) && wr_done && (addr == ADDR_LAST);

    oled_byte_writer #(
        .CLK_DIV (CLK_DIV)
    ) u_writer (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .dc_in   (wr_dc),
        .data_in (wr_data),
        .busy    (wr_busy),
        .done    (wr_done),
        .e       (oled_e),
        .dc      (oled_dc),
        .dout    (oled_dout)
    );

    // wr_busy is part of the writer handshake; the top never issues start
    // while a byte is in flight because pend/state already serialise it.
    logic unused_busy;
    assign unused_busy = wr_busy;

endmodule

// File: tb/tb_oled_ctrl.sv
// Directed bench for oled_ctrl on a small 16x8 panel so that several frames
// fit in a short run. A two-stage memory model returns addr[7:0] exactly
// PIXEL_LATENCY cycles after pixel_re and 8'hC3 at all other times.
module tb_oled_ctrl;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int DIV  = 4;
    localparam int RSTC = 20;
    localparam int WAITC = 30;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_re;
    logic [12:0] pixel_addr;
    logic [7:0]  pixel_data = 8'hC3;
    logic        frame_done;
    logic        oled_cs;
    logic        oled_rst;
    logic        oled_dc;
    logic        oled_e;
    logic [7:0]  oled_dout;
`ifdef OLED_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int re_count = 0;
    int fd_count = 0;
    int fd_cyc = -1;

    logic       mem_v1 = 1'b0;
    logic [7:0] mem_a1 = 8'h00;

    oled_ctrl #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .CLK_DIV       (DIV),
        .RST_CYCLES    (RSTC),
        .WAIT_CYCLES   (WAITC),
        .PIXEL_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef OLED_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .pixel_re   (pixel_re),
        .pixel_addr (pixel_addr),
        .pixel_data (pixel_data),
        .frame_done (frame_done),
        .oled_cs    (oled_cs),
        .oled_rst   (oled_rst),
        .oled_dc    (oled_dc),
        .oled_e     (oled_e),
        .oled_dout  (oled_dout)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory model: data valid LAT(=2) cycles after pixel_re.
    always @(posedge clk) begin
        mem_v1     <= (pixel_re === 1'b1);
        mem_a1     <= pixel_addr[7:0];
        pixel_data <= mem_v1 ? mem_a1 : 8'hC3;
    end

    // Event monitor for pixel_re and frame_done.
    always @(negedge clk) begin
        if (pixel_re === 1'b1) re_count <= re_count + 1;
        if (frame_done === 1'b1) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
    end

    // Waits for the next E rise and returns what was on the bus, the E-high
    // length, whether dc/dout stayed put, and the cycle of the E fall.
    task automatic get_byte(output logic dc, output logic [7:0] d, output int hi,
                            output bit held, output bit timeout, output int fall_cyc);
        int n;
        n = 0; hi = 0; held = 1'b1; timeout = 1'b0; dc = 1'b0; d = 8'h00; fall_cyc = 0;
        while (oled_e !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            timeout = 1'b1;
            return;
        end
        dc = oled_dc;
        d  = oled_dout;
        while (oled_e === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
            if (oled_dc !== dc || oled_dout !== d) held = 1'b0;
        end
        fall_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({oled_cs, oled_rst, oled_dc, oled_e, oled_dout, pixel_re, pixel_addr, frame_done}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 13'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: cs=%b rst=%b dc=%b e=%b dout=%h re=%b addr=%0d fd=%b, required 1 0 0 0 00 0 0 0",
                     oled_cs, oled_rst, oled_dc, oled_e, oled_dout, pixel_re, pixel_addr, frame_done);
        end
        rst = 1'b0;
        checks++;
        if ({oled_cs, oled_rst, oled_dc, oled_e, oled_dout, pixel_re, pixel_addr, frame_done}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 13'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_cycle: cs=%b rst=%b e=%b dout=%h addr=%0d, required 1 0 0 00 0",
                     oled_cs, oled_rst, oled_e, oled_dout, pixel_addr);
        end
    endtask

    // Called at the sample point of the first cycle after rst deasserts.
    task automatic test_power_up();
        int lo;
        int wt;
        bit rst_dropped;
        lo = 1;
        @(negedge clk);
        while (oled_rst === 1'b0 && lo < RSTC + 50) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (lo !== RSTC) begin
            errors++;
            $display("FAIL rst_low_cycles: got %0d required %0d", lo, RSTC);
        end
        wt = 0;
        rst_dropped = 1'b0;
        while (oled_cs === 1'b1 && wt < WAITC + 50) begin
            if (oled_rst !== 1'b1) rst_dropped = 1'b1;
            wt++;
            @(negedge clk);
        end
        checks++;
        if (wt !== WAITC || rst_dropped) begin
            errors++;
            $display("FAIL wait_cycles: got %0d (rst dropped %0b) required %0d", wt, rst_dropped, WAITC);
        end
    endtask

    task automatic test_commands();
        logic [7:0] exp_cmd [19];
        logic       dc;
        logic [7:0] d;
        int         hi;
        int         fc;
        int         r0;
        bit         held;
        bit         to;
        exp_cmd = '{8'hAE, 8'hA0, 8'h32, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
                    8'hAD, 8'h8E, 8'hAF, 8'h15, 8'h00, 8'(W-1), 8'h75, 8'h00, 8'(H-1)};
        r0 = re_count;
        for (int i = 0; i < 19; i++) begin
            get_byte(dc, d, hi, held, to, fc);
            checks++;
            if (to || d !== exp_cmd[i] || dc !== 1'b0 || hi !== DIV || !held ||
                oled_cs !== 1'b0 || oled_rst !== 1'b1) begin
                errors++;
                $display("FAIL cmd_byte[%0d]: got %h dc=%b ehigh=%0d held=%0b timeout=%0b cs=%b rst=%b, required %h dc=0 ehigh=%0d",
                         i, d, dc, hi, held, to, oled_cs, oled_rst, exp_cmd[i], DIV);
            end
        end
        checks++;
        if (re_count !== r0) begin
            errors++;
            $display("FAIL cmd_no_pixel_re: got %0d requests required 0", re_count - r0);
        end
    endtask

    // Checks n consecutive pixels starting at address first.
    task automatic test_pixel_stream(input int first, input int n, output int last_fall);
        logic       dc;
        logic [7:0] d;
        int         hi;
        int         fc;
        int         w;
        int         re_cyc;
        int         prev_re;
        bit         held;
        bit         to;
        prev_re = -1;
        last_fall = 0;
        for (int i = first; i < first + n; i++) begin
            w = 0;
            while (pixel_re !== 1'b1 && w < 2000) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 2000 || pixel_addr !== 13'(i)) begin
                errors++;
                $display("FAIL pixel_req[%0d]: addr=%0d timeout=%0b required addr %0d", i, pixel_addr, (w >= 2000), i);
            end
            re_cyc = cyc;
            if (prev_re >= 0) begin
                checks++;
                if (re_cyc - prev_re !== 14) begin
                    errors++;
                    $display("FAIL pixel_period[%0d]: got %0d required 14", i, re_cyc - prev_re);
                end
            end
            prev_re = re_cyc;
            @(negedge clk);
            checks++;
            if (pixel_re !== 1'b0) begin
                errors++;
                $display("FAIL pixel_re_width[%0d]: got %b required 0 one cycle after request", i, pixel_re);
            end
            get_byte(dc, d, hi, held, to, fc);
            last_fall = fc;
            checks++;
            if (to || d !== 8'(i) || dc !== 1'b1 || hi !== DIV || !held) begin
                errors++;
                $display("FAIL pixel_byte[%0d]: got %h dc=%b ehigh=%0d held=%0b timeout=%0b, required %h dc=1",
                         i, d, dc, hi, held, to, 8'(i));
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] exp_win [6];
        logic       dc;
        logic [7:0] d;
        int         hi;
        int         fc;
        int         fd0;
        int         last_fall;
        int         dummy;
        bit         held;
        bit         to;
        exp_win = '{8'h15, 8'h00, 8'(W-1), 8'h75, 8'h00, 8'(H-1)};
        fd0 = fd_count;
        test_pixel_stream(20, NPIX - 20, last_fall);
        checks++;
        if (fd_count !== fd0) begin
            errors++;
            $display("FAIL frame_done_early: got %0d pulses required 0 before last byte ends", fd_count - fd0);
        end
        for (int i = 0; i < 6; i++) begin
            get_byte(dc, d, hi, held, to, fc);
            checks++;
            if (to || d !== exp_win[i] || dc !== 1'b0) begin
                errors++;
                $display("FAIL wrap_cmd[%0d]: got %h dc=%b timeout=%0b required %h dc=0", i, d, dc, to, exp_win[i]);
            end
        end
        checks++;
        if (fd_count !== fd0 + 1 || fd_cyc !== last_fall + DIV - 1) begin
            errors++;
            $display("FAIL frame_done_pulse: got %0d pulses at cycle %0d required 1 at cycle %0d",
                     fd_count - fd0, fd_cyc, last_fall + DIV - 1);
        end
        test_pixel_stream(0, 2, dummy);
    endtask

    task automatic test_mid_byte_reset();
        int w;
        w = 0;
        while (pixel_re !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        while (oled_e !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        checks++;
        if (oled_e !== 1'b1 || oled_dc !== 1'b1 || pixel_addr === 13'd0) begin
            errors++;
            $display("FAIL mid_byte_setup: e=%b dc=%b addr=%0d required e=1 dc=1 addr nonzero", oled_e, oled_dc, pixel_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({oled_cs, oled_rst, oled_dc, oled_e, oled_dout, pixel_re, pixel_addr, frame_done}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 13'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_byte_reset: cs=%b rst=%b dc=%b e=%b dout=%h re=%b addr=%0d, required 1 0 0 0 00 0 0",
                     oled_cs, oled_rst, oled_dc, oled_e, oled_dout, pixel_re, pixel_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef OLED_TEST_PATTERN_EN
    task automatic test_test_pattern();
        logic [7:0] bars [8];
        logic       dc;
        logic [7:0] d;
        int         hi;
        int         fc;
        bit         held;
        bit         to;
        bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
        test_pattern = 1'b1;
        for (int x = 0; x < W; x++) begin
            get_byte(dc, d, hi, held, to, fc);
            checks++;
            if (to || d !== bars[(x * 8) / W] || dc !== 1'b1) begin
                errors++;
                $display("FAIL bar_byte[%0d]: got %h dc=%b required %h dc=1", x, d, dc, bars[(x * 8) / W]);
            end
        end
        test_pattern = 1'b0;
    endtask
`endif

    initial begin
        int dummy;
        test_reset();
        test_power_up();
        test_commands();
        test_pixel_stream(0, 20, dummy);
        test_frame_wrap();
        test_mid_byte_reset();
        test_power_up();
        test_commands();
`ifdef OLED_TEST_PATTERN_EN
        test_test_pattern();
`else
        test_pixel_stream(0, 3, dummy);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
